// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - core load/store to word-memory initiator with sub-word RMW
module lsu_mem_initiator #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        misalign;
  logic        bad_f3;
  logic        out_of_range;
  logic [31:0] shifted;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign accept = req_valid & req_ready;

  // Request legality is judged on the live inputs so the accept edge can route straight to RESP.
  always_comb begin
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we)
      bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      bad_f3 = (req_funct3 inside {3'b011, 3'b110, 3'b111});
    out_of_range = (req_addr >= ADDR_LIMIT);
    req_err      = misalign | bad_f3 | out_of_range;
  end

  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = f3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Byte/half replacement uses a shifted lane mask so one expression covers sb and sh.
  always_comb begin
    if (f3_q[1:0] == 2'b00) begin
      lane_sh   = {addr_q[1:0], 3'b000};
      lane_mask = 32'h0000_00ff << lane_sh;
      lane_data = {24'h0, wdata_q[7:0]} << lane_sh;
    end else begin
      lane_sh   = {addr_q[1], 4'b0000};
      lane_mask = 32'h0000_ffff << lane_sh;
      lane_data = {16'h0, wdata_q[15:0]} << lane_sh;
    end
    merged = (old_q & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = (we_q && (f3_q != 3'b010)) ? MERGE : RESP;
      MERGE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write enable comes from state alone so core-side input changes never glitch it.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    if (state == MERGE) begin
      mem_we    = 1'b1;
      mem_wdata = merged;
    end else if ((state == ACCESS) && we_q && (f3_q == 3'b010)) begin
      mem_we    = 1'b1;
      mem_wdata = wdata_q;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      old_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= req_err;
      end else if (state == ACCESS) begin
        if (we_q)
          old_q <= mem_rdata;
        else
          rdata_q <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed self-checking bench for lsu_mem_initiator
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [31:0] last_waddr = 32'h0;
  int cyc = 0;
  int rsp_cnt = 0;
  int acc_t [$];
  logic [31:0] rsp_q [$];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (req_valid && req_ready) acc_t.push_back(cyc);
    if (mem_we) begin
      mem[mem_addr[7:2]] = mem_wdata;
      we_cnt = we_cnt + 1;
      last_waddr = mem_addr;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt = rsp_cnt + 1;
      rsp_q.push_back(rsp_rdata);
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic e,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 99; rd = 32'hx; e = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; e = rsp_err;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse_width: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b rd=%h err=%b we=%b addr=%h wd=%h required 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_chk(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_rd);
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = we_cnt;
    do_req(1'b0, f3, addr, 32'h0, rd, e, lat);
    checks++;
    if (rd !== exp_rd || e !== 1'b0 || lat != 2 || we_cnt != w0) begin
      errors++;
      $display("FAIL %s: rdata=%h err=%b lat=%0d writes=%0d required %h 0 2 0", nm, rd, e, lat, we_cnt - w0, exp_rd);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = we_cnt;
    do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rd, e, lat);
    checks++;
    if (we_cnt - w0 != 1 || last_waddr !== 32'h8 || mem[2] !== 32'hDEADBEEF || lat != 2 ||
        rd !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_0x8: writes=%0d waddr=%h word=%h lat=%0d rd=%h err=%b required 1 8 deadbeef 2 0 0",
               we_cnt - w0, last_waddr, mem[2], lat, rd, e);
    end
    load_chk("lw_0x8", 3'b010, 32'h8, 32'hDEADBEEF);
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = we_cnt;
    do_req(1'b1, 3'b000, 32'h9, 32'hFFFFFF55, rd, e, lat);
    checks++;
    if (we_cnt - w0 != 1 || mem[2] !== 32'hDEAD55EF || lat != 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_0x9: writes=%0d word=%h lat=%0d err=%b required 1 dead55ef 3 0", we_cnt - w0, mem[2], lat, e);
    end
    load_chk("lb_0x9", 3'b000, 32'h9, 32'h00000055);
    load_chk("lbu_0xb", 3'b100, 32'hB, 32'h000000DE);
    load_chk("lb_0xb", 3'b000, 32'hB, 32'hFFFFFFDE);
  endtask

  task automatic test_half;
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = we_cnt;
    do_req(1'b1, 3'b001, 32'hA, 32'h12348001, rd, e, lat);
    checks++;
    if (we_cnt - w0 != 1 || mem[2] !== 32'h800155EF || lat != 3) begin
      errors++;
      $display("FAIL sh_0xa: writes=%0d word=%h lat=%0d required 1 800155ef 3", we_cnt - w0, mem[2], lat);
    end
    load_chk("lh_0xa", 3'b001, 32'hA, 32'hFFFF8001);
    load_chk("lhu_0xa", 3'b101, 32'hA, 32'h00008001);
    load_chk("lh_0x8", 3'b001, 32'h8, 32'h000055EF);
  endtask

  task automatic err_chk(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] rd; logic e; int lat; int w0;
    w0 = we_cnt;
    do_req(we, f3, addr, 32'hFFFFFFFF, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || lat != 1 || we_cnt != w0) begin
      errors++;
      $display("FAIL %s: err=%b rdata=%h lat=%0d writes=%0d required 1 0 1 0", nm, e, rd, lat, we_cnt - w0);
    end
  endtask

  task automatic test_errors;
    err_chk("err_lw_0x6", 1'b0, 3'b010, 32'h6);
    err_chk("err_sh_0x3", 1'b1, 3'b001, 32'h3);
    err_chk("err_f3_011", 1'b0, 3'b011, 32'h4);
    err_chk("err_sw_0x100", 1'b1, 3'b010, 32'h100);
    err_chk("err_store_f3_100", 1'b1, 3'b100, 32'h4);
    load_chk("lw_0xfc_edge", 3'b010, 32'hFC, 32'h0);
  endtask

  task automatic test_back_to_back;
    int n0; int g;
    logic [31:0] wd [4]; logic [2:0] f3 [4]; logic [31:0] ad [4]; logic w [4];
    n0 = rsp_q.size();
    acc_t.delete();
    w[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h0; wd[0] = 32'h11223344;
    w[1] = 1'b0; f3[1] = 3'b010; ad[1] = 32'h0; wd[1] = 32'h0;
    w[2] = 1'b1; f3[2] = 3'b000; ad[2] = 32'h1; wd[2] = 32'h000000AA;
    w[3] = 1'b0; f3[3] = 3'b100; ad[3] = 32'h1; wd[3] = 32'h0;
    @(negedge clk);
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_we = w[k]; req_funct3 = f3[k]; req_addr = ad[k]; req_wdata = wd[k];
      g = 0;
      while (!req_ready && g < 20) begin
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 && rsp_valid === 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_busy: req_ready=%b while rsp_valid required 0", req_ready);
        end
        g++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (acc_t.size() != 4 || acc_t[1] - acc_t[0] != 3 || acc_t[2] - acc_t[1] != 3 || acc_t[3] - acc_t[2] != 4) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d,%0d required 4 3,3,4", acc_t.size(),
               acc_t[1] - acc_t[0], acc_t[2] - acc_t[1], acc_t[3] - acc_t[2]);
    end
    checks++;
    if (rsp_q.size() - n0 != 4 || rsp_q[n0 + 1] !== 32'h11223344 || rsp_q[n0 + 3] !== 32'h000000AA ||
        mem[0] !== 32'h1122AA44) begin
      errors++;
      $display("FAIL b2b_results: rsps=%0d lw=%h lbu=%h word0=%h required 4 11223344 000000aa 1122aa44",
               rsp_q.size() - n0, rsp_q[n0 + 1], rsp_q[n0 + 3], mem[0]);
    end
  endtask

  task automatic test_reset_mid_merge;
    logic [31:0] rd; logic e; int lat; int w0; int r0;
    do_req(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, rd, e, lat);
    w0 = we_cnt; r0 = rsp_cnt;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL merge_we_before_reset: mem_we=%b required 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_drops_we: mem_we=%b wdata=%h required 0 0", mem_we, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem[1] !== 32'hCAFEF00D || we_cnt != w0 || rsp_cnt != r0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_merge: word1=%h writes=%0d rsps=%0d ready=%b required cafef00d 0 0 1",
               mem[1], we_cnt - w0, rsp_cnt - r0, req_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_reset_mid_merge;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
